// File: rtl/mux_arb_nway.sv
// mux_arb_nway: CANAIS-channel, LARGURA-bit mux/arbiter with a registered valid/ready output.
// Fixed-select or round-robin grant; define MUX_ARB_LOCK_EN to add packet locking via entrada_fim.
module mux_arb_nway #(
    parameter int LARGURA = 16,
    parameter int CANAIS  = 8,
    localparam int SEL_W  = $clog2(CANAIS)
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef MUX_ARB_LOCK_EN
    input  logic [CANAIS-1:0]         entrada_fim,
`endif
    input  logic [CANAIS*LARGURA-1:0] entrada_dados,
    input  logic [CANAIS-1:0]         entrada_valida,
    output logic [CANAIS-1:0]         entrada_pronta,
    input  logic                      modo,
    input  logic [SEL_W-1:0]          seletor_ctrl,
    output logic [LARGURA-1:0]        saida_dados,
    output logic                      saida_valida,
    input  logic                      saida_pronta,
    output logic [SEL_W-1:0]          saida_canal
);
    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(CANAIS - 1);
    localparam logic [SEL_W:0]   LIMITE = (SEL_W + 1)'(CANAIS);

    logic [SEL_W-1:0]   ptr;
    logic               pode_carregar;
    logic               transfere;
    logic               fix_ok;
    logic               rr_ok;
    logic               grant_ok;
    logic [SEL_W-1:0]   rr_g;
    logic [SEL_W-1:0]   grant_g;
    logic [SEL_W:0]     idx;
    logic [LARGURA-1:0] dados_sel;

    assign pode_carregar = !saida_valida || saida_pronta;

    // An out-of-range select matches no channel, so it never grants.
    always_comb begin
        fix_ok = 1'b0;
        for (int unsigned k = 0; k < CANAIS; k++) begin
            if (seletor_ctrl == SEL_W'(k) && entrada_valida[k]) fix_ok = 1'b1;
        end
    end

    // Scan ptr+1 .. ptr+CANAIS, wrapping at CANAIS rather than at 2**SEL_W.
    always_comb begin
        rr_ok = 1'b0;
        rr_g  = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= CANAIS; i++) begin
            idx = {1'b0, ptr} + (SEL_W + 1)'(i);
            if (idx >= LIMITE) idx = idx - LIMITE;
            if (!rr_ok && entrada_valida[idx[SEL_W-1:0]]) begin
                rr_ok = 1'b1;
                rr_g  = idx[SEL_W-1:0];
            end
        end
    end

`ifdef MUX_ARB_LOCK_EN
    typedef enum logic {LIVRE, TRAVADO} estado_t;
    estado_t          estado;
    estado_t          estado_prox;
    logic [SEL_W-1:0] canal_trava;

    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= LIVRE;
            canal_trava <= '0;
        end else begin
            estado <= estado_prox;
            if (modo && transfere) canal_trava <= grant_g;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            LIVRE:   if (modo && transfere && !entrada_fim[grant_g]) estado_prox = TRAVADO;
            TRAVADO: begin
                if (!modo) estado_prox = LIVRE;
                else if (transfere && entrada_fim[grant_g]) estado_prox = LIVRE;
            end
            default: estado_prox = LIVRE;
        endcase
    end

    // While locked only the owning channel may be granted, valid or not.
    always_comb begin
        grant_ok = rr_ok;
        grant_g  = rr_g;
        if (!modo) begin
            grant_ok = fix_ok;
            grant_g  = seletor_ctrl;
        end else if (estado == TRAVADO) begin
            grant_ok = entrada_valida[canal_trava];
            grant_g  = canal_trava;
        end
    end
`else
    always_comb begin
        grant_ok = rr_ok;
        grant_g  = rr_g;
        if (!modo) begin
            grant_ok = fix_ok;
            grant_g  = seletor_ctrl;
        end
    end
`endif

    assign transfere = pode_carregar && grant_ok && !reset;

    always_comb begin
        entrada_pronta = '0;
        if (transfere) entrada_pronta[grant_g] = 1'b1;
    end

    always_comb begin
        dados_sel = '0;
        for (int unsigned k = 0; k < CANAIS; k++) begin
            if (grant_g == SEL_W'(k)) dados_sel = entrada_dados[k*LARGURA +: LARGURA];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            saida_dados  <= '0;
            saida_canal  <= '0;
            saida_valida <= 1'b0;
            ptr          <= ULTIMO;
        end else if (transfere) begin
            saida_dados  <= dados_sel;
            saida_canal  <= grant_g;
            saida_valida <= 1'b1;
            if (modo) ptr <= grant_g;
        end else if (saida_pronta) begin
            saida_valida <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mux_arb_nway.sv
// Self-checking bench for mux_arb_nway: an 8-channel and a 5-channel instance checked every
// cycle against a queue-free behavioural model, plus directed literal checks.
module tb_mux_arb_nway;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din  [2];
    logic [7:0]   vld  [2];
    logic [7:0]   fim  [2];
    logic         modo_s [2];
    logic [2:0]   sel  [2];
    logic         sp   [2];

    logic [7:0]  pr8;
    logic [4:0]  pr5;
    logic [15:0] d8, d5;
    logic [2:0]  c8, c5;
    logic        v8, v5;

    int checks = 0;
    int errors = 0;

    // Model state per instance
    bit          m_v   [2];
    logic [15:0] m_d   [2];
    int          m_c   [2];
    int          m_ptr [2];
    bit          m_lk  [2];
    int          m_lc  [2];

    always #5 clk = ~clk;

    mux_arb_nway #(.LARGURA(16), .CANAIS(8)) u8 (
        .clk(clk), .reset(rst),
`ifdef MUX_ARB_LOCK_EN
        .entrada_fim(fim[0]),
`endif
        .entrada_dados(din[0]), .entrada_valida(vld[0]), .entrada_pronta(pr8),
        .modo(modo_s[0]), .seletor_ctrl(sel[0]),
        .saida_dados(d8), .saida_valida(v8), .saida_pronta(sp[0]), .saida_canal(c8)
    );

    mux_arb_nway #(.LARGURA(16), .CANAIS(5)) u5 (
        .clk(clk), .reset(rst),
`ifdef MUX_ARB_LOCK_EN
        .entrada_fim(fim[1][4:0]),
`endif
        .entrada_dados(din[1][79:0]), .entrada_valida(vld[1][4:0]), .entrada_pronta(pr5),
        .modo(modo_s[1]), .seletor_ctrl(sel[1]),
        .saida_dados(d5), .saida_valida(v5), .saida_pronta(sp[1]), .saida_canal(c5)
    );

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s[u%0d] actual=%0h required=%0h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Channel that wins this cycle, or -1 when none does.
    function automatic int grant(input int n, input logic [7:0] v, input logic md, input int s,
                                 input int p, input bit lk, input int lc);
        if (!md) return (s < n && v[s]) ? s : -1;
        if (lk) return v[lc] ? lc : -1;
        for (int i = 1; i <= n; i++) begin
            if (v[(p + i) % n]) return (p + i) % n;
        end
        return -1;
    endfunction

    initial begin
        for (int j = 0; j < 2; j++) begin
            m_v[j] = 0; m_d[j] = '0; m_c[j] = 0; m_ptr[j] = (j == 0) ? 7 : 4;
            m_lk[j] = 0; m_lc[j] = 0;
        end
    end

    // Single compare process: check every output against the model, then advance the model
    // using the inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        int n;
        int g;
        bit free;
        logic [7:0] ep;
        logic [7:0] ap;
        for (int j = 0; j < 2; j++) begin
            n  = (j == 0) ? 8 : 5;
            g  = grant(n, vld[j], modo_s[j], int'(sel[j]), m_ptr[j], m_lk[j], m_lc[j]);
            free = !m_v[j] || sp[j];
            ep = '0;
            if (!rst && free && g >= 0) ep[g] = 1'b1;
            ap = (j == 0) ? pr8 : {3'b000, pr5};
            chk("pronta", j, 32'(ap), 32'(ep));
            chk("valida", j, 32'((j == 0) ? v8 : v5), 32'(m_v[j]));
            chk("dados",  j, 32'((j == 0) ? d8 : d5), 32'(m_d[j]));
            chk("canal",  j, 32'((j == 0) ? c8 : c5), 32'(m_c[j]));

            if (rst) begin
                m_v[j] = 0; m_d[j] = '0; m_c[j] = 0; m_ptr[j] = n - 1; m_lk[j] = 0;
            end else begin
                if (free && g >= 0) begin
                    m_v[j] = 1;
                    m_d[j] = din[j][g*16 +: 16];
                    m_c[j] = g;
                    if (modo_s[j]) m_ptr[j] = g;
`ifdef MUX_ARB_LOCK_EN
                    if (modo_s[j]) begin
                        m_lk[j] = !fim[j][g];
                        m_lc[j] = g;
                    end
`endif
                end else if (sp[j]) begin
                    m_v[j] = 0;
                end
                if (!modo_s[j]) m_lk[j] = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int j = 0; j < 2; j++) begin
            vld[j] = 8'hFF; modo_s[j] = 1'b1; sel[j] = '0; sp[j] = 1'b1; fim[j] = '0;
            din[j] = {$urandom, $urandom, $urandom, $urandom};
        end
        vld[1] = 8'h11;

        // Reset held for two edges with every channel valid
        @(negedge clk);
        chk("rst_pronta", 0, 32'(pr8), 32'h0);
        chk("rst_valida", 0, 32'(v8), 32'h0);
        chk("rst_dados",  0, 32'(d8), 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("first_rr", 0, 32'(pr8), 32'h01);
        chk("first_rr", 1, 32'(pr5), 32'h01);

        // Round-robin fairness on u8; ch4/ch0 alternation with wrap at 5 on u5
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk);
            chk("rr_seq", 0, 32'(c8), 32'(i % 8));
            chk("rr_valid", 0, 32'(v8), 32'h1);
            chk("rr_wrap5", 1, 32'(c5), (i % 2 == 0) ? 32'd0 : 32'd4);
        end

        // Fixed select: ch5 on u8, out-of-range 6 on u5
        step();
        modo_s[0] = 1'b0; sel[0] = 3'd5; din[0][80 +: 16] = 16'hA5A5;
        modo_s[1] = 1'b0; sel[1] = 3'd6;
        @(negedge clk);
        chk("fix_pronta", 0, 32'(pr8), 32'b0010_0000);
        chk("oor_pronta", 1, 32'(pr5), 32'h0);
        step();
        @(negedge clk);
        chk("fix_dados", 0, 32'(d8), 32'hA5A5);
        chk("fix_canal", 0, 32'(c8), 32'd5);
        chk("oor_valida", 1, 32'(v5), 32'h0);

        // Backpressure: beat held for 3 cycles, then next grant is ptr+1 (ptr=2)
        step();
        modo_s[0] = 1'b1; sp[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_dados", 0, 32'(d8), 32'hA5A5);
            chk("stall_canal", 0, 32'(c8), 32'd5);
            chk("stall_pronta", 0, 32'(pr8), 32'h0);
            step();
        end
        sp[0] = 1'b1;
        @(negedge clk);
        chk("release_pronta", 0, 32'(pr8), 32'b0000_1000);
        step();
        @(negedge clk);
        chk("release_canal", 0, 32'(c8), 32'd3);

`ifdef MUX_ARB_LOCK_EN
        // Packet lock: ch2 sends fim=0,0,1 while ch3 waits
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; vld[0] = 8'b0000_1100; fim[0] = 8'h00; modo_s[0] = 1'b1; sp[0] = 1'b1;
        @(negedge clk);
        chk("lock_g0", 0, 32'(pr8), 32'b0000_0100);
        step();
        fim[0] = 8'h00;
        @(negedge clk);
        chk("lock_c1", 0, 32'(c8), 32'd2);
        chk("lock_g1", 0, 32'(pr8), 32'b0000_0100);
        step();
        fim[0] = 8'b0000_0100;
        @(negedge clk);
        chk("lock_c2", 0, 32'(c8), 32'd2);
        chk("lock_g2", 0, 32'(pr8), 32'b0000_0100);
        step();
        fim[0] = 8'h00;
        @(negedge clk);
        chk("lock_c3", 0, 32'(c8), 32'd2);
        chk("unlock_g", 0, 32'(pr8), 32'b0000_1000);
        step();
        @(negedge clk);
        chk("unlock_c", 0, 32'(c8), 32'd3);
`endif

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 199) == 0);
            for (int j = 0; j < 2; j++) begin
                vld[j]    = 8'($urandom);
                fim[j]    = 8'($urandom);
                modo_s[j] = ($urandom_range(0, 3) != 0);
                sel[j]    = 3'($urandom);
                sp[j]     = ($urandom_range(0, 3) != 0);
                din[j]    = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        step();
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
